// File: rtl/exec_win_pkg.sv
// Shared types and defaults for the execution-window generator.
package exec_win_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      ACTIVE,
      GAP,
      DONE
   } win_state_e;

   localparam int CNT_W_DEF  = 8;
   localparam int REP_W_DEF  = 4;
   localparam int LEGACY_LEN = 6;

endpackage

// File: rtl/exec_win_cnt.sv
// Loadable down-counter shared by the delay, window and gap phases.
module exec_win_cnt
   import exec_win_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   // Load value is phase length minus one, so expiry marks the last cycle.
   always_ff @(posedge clk) begin
      if (rst)               cnt <= '0;
      else if (load)         cnt <= load_val;
      else if (cnt != '0)    cnt <= cnt - CNT_W'(1);
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/exec_window_gen.sv
// Execution-window enable generator: delay, repeated windows with gaps, trigger and done.
module exec_window_gen
   import exec_win_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = CNT_W_DEF,
   parameter int REP_W = REP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_dly,
   input  logic [CNT_W-1:0] cfg_gap,
   input  logic [REP_W-1:0] cfg_rep,
   input  logic [N_CH-1:0]  ch_mask,
   output logic [N_CH-1:0]  enable,
   output logic             trig_out,
   output logic             busy,
   output logic             done,
   output logic [REP_W-1:0] rep_idx
);

   win_state_e       state;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] gap_q;
   logic [REP_W-1:0] rep_q;
   logic [N_CH-1:0]  mask_q;

   logic [CNT_W-1:0] len_in;
   logic             launch;
   logic             more;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_exp;

   assign len_in = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
   assign launch = (state == IDLE) && start && !abort;
   assign more   = (rep_idx < rep_q);

   // Counter is reloaded on every phase entry, including back-to-back windows.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state)
         IDLE: if (launch) begin
            cnt_load = 1'b1;
            cnt_val  = (cfg_dly != '0) ? cfg_dly - CNT_W'(1) : len_in - CNT_W'(1);
         end
         DELAY, GAP: if (cnt_exp) begin
            cnt_load = 1'b1;
            cnt_val  = len_q - CNT_W'(1);
         end
         ACTIVE: if (cnt_exp && more) begin
            cnt_load = 1'b1;
            cnt_val  = (gap_q != '0) ? gap_q - CNT_W'(1) : len_q - CNT_W'(1);
         end
         default: ;
      endcase
   end

   exec_win_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .expired  (cnt_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         len_q    <= '0;
         gap_q    <= '0;
         rep_q    <= '0;
         mask_q   <= '0;
         enable   <= '0;
         trig_out <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rep_idx  <= '0;
      end else begin
         trig_out <= 1'b0;
         done     <= 1'b0;
         if (abort && state != IDLE) begin
            state  <= IDLE;
            enable <= '0;
            busy   <= 1'b0;
         end else begin
            case (state)
               IDLE: if (launch) begin
                  len_q   <= len_in;
                  gap_q   <= cfg_gap;
                  rep_q   <= cfg_rep;
                  mask_q  <= ch_mask;
                  rep_idx <= '0;
                  busy    <= 1'b1;
                  if (cfg_dly == '0) begin
                     state    <= ACTIVE;
                     enable   <= ch_mask;
                     trig_out <= 1'b1;
                  end else begin
                     state <= DELAY;
                  end
               end
               DELAY: if (cnt_exp) begin
                  state    <= ACTIVE;
                  enable   <= mask_q;
                  trig_out <= 1'b1;
               end
               ACTIVE: if (cnt_exp) begin
                  if (more) begin
                     rep_idx <= rep_idx + REP_W'(1);
                     if (gap_q != '0) begin
                        state  <= GAP;
                        enable <= '0;
                     end
                  end else begin
                     state  <= DONE;
                     enable <= '0;
                     done   <= 1'b1;
                  end
               end
               GAP: if (cnt_exp) begin
                  state  <= ACTIVE;
                  enable <= mask_q;
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_exec_window_gen.sv
// Directed bench for exec_window_gen: per-cycle traces against hand-computed bit maps.
module tb_exec_window_gen;
   import exec_win_pkg::*;

   localparam int N_CH  = 4;
   localparam int CNT_W = 8;
   localparam int REP_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] cfg_len;
   logic [CNT_W-1:0] cfg_dly;
   logic [CNT_W-1:0] cfg_gap;
   logic [REP_W-1:0] cfg_rep;
   logic [N_CH-1:0]  ch_mask;
   logic [N_CH-1:0]  enable;
   logic             trig_out;
   logic             busy;
   logic             done;
   logic [REP_W-1:0] rep_idx;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   exec_window_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .cfg_len  (cfg_len),
      .cfg_dly  (cfg_dly),
      .cfg_gap  (cfg_gap),
      .cfg_rep  (cfg_rep),
      .ch_mask  (ch_mask),
      .enable   (enable),
      .trig_out (trig_out),
      .busy     (busy),
      .done     (done),
      .rep_idx  (rep_idx)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int len, input int dly, input int gap, input int rep,
                      input logic [N_CH-1:0] m);
      cfg_len = CNT_W'(len);
      cfg_dly = CNT_W'(dly);
      cfg_gap = CNT_W'(gap);
      cfg_rep = REP_W'(rep);
      ch_mask = m;
   endtask

   // Bit c of each map is the expected value in relative cycle c; inputs driven
   // in cycle c are sampled at the end of it. rep_idx is expected to be
   // (c>=r1)+(c>=r2) from cycle rep_from on.
   task automatic trace(input string tag, input int ncyc,
                        input logic [31:0] start_b, input logic [31:0] abort_b,
                        input logic [31:0] rst_b, input int chg_at,
                        input logic [N_CH-1:0] m,
                        input logic [31:0] en_b, input logic [31:0] trig_b,
                        input logic [31:0] done_b, input logic [31:0] busy_b,
                        input int rep_from, input int r1, input int r2);
      for (int c = 0; c < ncyc; c++) begin
         start = start_b[c];
         abort = abort_b[c];
         rst   = rst_b[c];
         if (c == chg_at) cfg(1, 7, 3, 3, '0);
         chk($sformatf("%s/en@%0d", tag, c),   32'(enable),   en_b[c] ? 32'(m) : 32'd0);
         chk($sformatf("%s/trig@%0d", tag, c), 32'(trig_out), 32'(trig_b[c]));
         chk($sformatf("%s/done@%0d", tag, c), 32'(done),     32'(done_b[c]));
         chk($sformatf("%s/busy@%0d", tag, c), 32'(busy),     32'(busy_b[c]));
         if (c >= rep_from)
            chk($sformatf("%s/rep@%0d", tag, c), 32'(rep_idx),
                32'(int'(c >= r1) + int'(c >= r2)));
         tick();
      end
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      cfg(0, 0, 0, 0, '0);
      tick();
      tick();
      chk("rst/en",   32'(enable),   32'd0);
      chk("rst/trig", 32'(trig_out), 32'd0);
      chk("rst/busy", 32'(busy),     32'd0);
      chk("rst/done", 32'(done),     32'd0);
      chk("rst/rep",  32'(rep_idx),  32'd0);
      rst = 1'b0;
      tick();

      // Legacy: len=6, start at 10 -> enable 11..16, trig 11, done 17, busy 11..17
      cfg(LEGACY_LEN, 0, 5, 0, 4'b0001);
      trace("legacy", 20, 32'h400, 0, 0, 99, 4'b0001,
            32'h1F800, 32'h800, 32'h20000, 32'h3F800, 0, 99, 99);

      // Delay 2, len 3, gap 1, rep 2; extra start in the DONE cycle (14) is ignored
      cfg(3, 2, 1, 2, 4'b1010);
      trace("dlyrep", 16, 32'h4001, 0, 0, 99, 4'b1010,
            32'h3BB8, 32'h8, 32'h4000, 32'h7FFE, 1, 6, 10);

      // len=0 treated as 1, gap=0 -> back-to-back windows at 1 and 2
      cfg(0, 0, 0, 1, 4'b1111);
      trace("zero", 6, 32'h1, 0, 0, 99, 4'b1111,
            32'h6, 32'h2, 32'h8, 32'hE, 1, 2, 99);

      // Abort at 4 of a len=10 window, relaunch at 6 -> window 7..16, done 17
      cfg(10, 0, 0, 0, 4'b0110);
      trace("abort", 20, 32'h41, 32'h10, 0, 99, 4'b0110,
            32'h1FF9E, 32'h82, 32'h20000, 32'h3FF9E, 1, 99, 99);

      // start and abort together in IDLE -> nothing launches
      cfg(4, 0, 0, 0, 4'b1001);
      trace("coll", 4, 32'h1, 32'h1, 0, 99, 4'b1001,
            32'h0, 32'h0, 32'h0, 32'h0, 1, 99, 99);

      // Second start and config change during ACTIVE are ignored
      cfg(4, 0, 0, 0, 4'b1001);
      trace("ignore", 8, 32'h5, 0, 0, 2, 4'b1001,
            32'h1E, 32'h2, 32'h20, 32'h3E, 1, 99, 99);

      // rst at 3 of a len=8 window -> all quiet from 4, no restart by itself
      cfg(8, 0, 0, 0, 4'b1100);
      trace("rstmid", 8, 32'h1, 0, 32'h8, 99, 4'b1100,
            32'hE, 32'h2, 32'h0, 32'hE, 1, 99, 99);
      trace("rstnew", 11, 32'h1, 0, 0, 99, 4'b1100,
            32'h1FE, 32'h2, 32'h200, 32'h3FE, 1, 99, 99);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exec_window_gen.md
Name: exec_window_gen

Overview:
- Parametrised generator for the execution-window enable. It supersedes the fixed six-cycle working flag in the SASEBO-GIII top level.
- Takes a start pulse derived from the local-bus data-ready strobe. After a programmable delay it drives a multi-channel enable window of programmable length, optionally repeated with programmable gaps.
- Outputs are a per-channel enable for the arithmetic cores under test, a scope trigger, busy and done.

Parameters:
- N_CH, 4, number of enable channels (one per core instance).
- CNT_W, 8, width of the length, delay and gap counters.
- REP_W, 4, width of the repeat count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  launch request, sampled only in IDLE
- abort  in  1  synchronous cancel
- cfg_len  in  CNT_W  active-window length in cycles; 0 is treated as 1
- cfg_dly  in  CNT_W  cycles from start to the first window
- cfg_gap  in  CNT_W  idle cycles between repeated windows
- cfg_rep  in  REP_W  extra repetitions (total windows = cfg_rep+1)
- ch_mask  in  N_CH  channels enabled during windows
- enable  out  N_CH  per-channel enable, registered
- trig_out  out  1  one-cycle pulse on the first enable cycle of the first window
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at sequence completion
- rep_idx  out  REP_W  index of the current window, 0-based

Behaviour:
- Reset: synchronous, active-high, clk and rst as named above. On rst, state=IDLE. enable=0, trig_out=0, busy=0, done=0, rep_idx=0, all counters 0. rst mid-sequence takes effect the same edge as any other input.
- All outputs are registered.
- States: IDLE, DELAY, ACTIVE, GAP, DONE.
- IDLE: on start, capture cfg_len (0 becomes 1), cfg_dly, cfg_gap, cfg_rep and ch_mask into shadow registers. Config changes after this are ignored until the next start.
  - If dly=0, go to ACTIVE; otherwise go to DELAY.
- Timing for start high at edge T:
  - dly=0: enable=mask_q during cycles T+1..T+len. This matches the legacy behaviour when len=6.
  - dly=D: enable is active during T+1+D..T+D+len.
- DELAY: count dly cycles, then go to ACTIVE.
- ACTIVE: enable=mask_q for len cycles. At the end:
  - if rep_idx<rep_q: increment rep_idx, then go to GAP (gap>0) or back-to-back ACTIVE (gap=0, no idle cycle between windows);
  - otherwise go to DONE.
- GAP: enable=0 for gap cycles, then go to ACTIVE.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE. rep_idx holds its last value until the next start.
- trig_out: single pulse, aligned with the first ACTIVE cycle of window 0 only.
- start while not IDLE: ignored. It is not queued.
- abort in any non-IDLE state: the next cycle is IDLE, enable=0 and busy=0, and no done pulse is produced.
- abort and start in the same cycle in IDLE: abort wins and no launch occurs.
- start in the DONE cycle: ignored.
- Counters: CNT_W-bit down-counters; no wrap is possible because loads are clamped. Maximum window is 2^CNT_W-1 cycles.

Decomposition:
- Shared package exec_win_pkg holds:
  - the state enum typedef (IDLE, DELAY, ACTIVE, GAP, DONE);
  - default widths CNT_W_DEF=8 and REP_W_DEF=4;
  - LEGACY_LEN=6.
- One sub-module is natural: exec_win_cnt. It is a loadable CNT_W down-counter with a load value and an expiry flag, reused for the delay, length and gap phases. The FSM and output registers stay in the parent.

Test Plan:
- Legacy equivalence: len=6, dly=0, rep=0, mask=4'b0001, start pulse at cycle 10 -> enable[0] high cycles 11-16, trig_out at 11, done at 17, busy 11-17.
- Delay plus repeat: len=3, dly=2, gap=1, rep=2, mask=4'b1010, start at 0 -> enable=4'b1010 during 3-5, 7-9 and 11-13; rep_idx 0/1/2; done at 14.
- Zero gap and zero length: len=0, gap=0, rep=1, start at 0 -> enable high cycles 1-2 back-to-back, rep_idx goes 0 then 1, done at 3.
- Abort: len=10, start at 0, abort at cycle 4 -> enable=0 and busy=0 from cycle 5, done never pulses; a new start at 6 launches normally.
- Collisions: start and abort together in IDLE -> no launch. A second start during ACTIVE -> ignored, window length unchanged. Config changed mid-sequence -> no effect.
- Reset mid-operation: rst high at cycle 3 of a len=8 window -> all outputs 0 at the next edge; the sequence resumes only on a new start after rst drops.
